pipelined_cla_adder: RTL
========================

Name: pipelined_cla_adder

Overview:
Parametrised, pipelined successor to the combinational N-bit carry-look-ahead adder. The datapath is split into WIDTH/SEG_W segments. Each segment is a SEG_W-bit CLA in its own pipeline stage, and carries ride in registers between stages. The block adds add/subtract mode, signed-overflow and zero flags, and a valid/ready handshake with full backpressure. It sits between operand-producing logic and the ALU writeback path wherever a wide adder would break timing.

Parameters:
WIDTH, 16, operand and result width in bits; must be a multiple of SEG_W.
SEG_W, 4, bits per CLA segment and per pipeline stage; NSEG = WIDTH/SEG_W (>=1).

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat valid
in_ready  output  1  block can accept operand beat this cycle
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry in; used in add mode only
sub  input  1  0 = A+B+cin, 1 = A-B (A + ~B + 1; cin ignored)
out_valid  output  1  result beat valid
out_ready  input  1  consumer accepts result this cycle
sum  output  WIDTH  result
cout  output  1  carry out of MSB; in sub mode 1 = no borrow
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB
zero  output  1  sum == 0

Behaviour:
- One clock domain. Reset is asynchronous, active-low. On assertion, all stage valid bits and all data/flag registers clear to 0 immediately. Resulting outputs: out_valid=0, sum=0, cout=0, ovf=0, zero=0. in_ready=1 from the first cycle after release.
- Reset mid-operation discards every in-flight beat. No partial or stale result appears after release.
- Transfer rules: input accepted on an edge with in_valid && in_ready; output consumed on an edge with out_valid && out_ready.
- Stage k (0..NSEG-1) holds v_k, the carry into the segment, accumulated lower sum bits, and the remaining upper operand bits. B is already inverted in sub mode; inversion and carry-in selection happen at stage-0 capture.
- Stage k computes segment k with generate/propagate look-ahead logic, not ripple. It registers segment sum bits, the segment carry out, and the MSB carry-in (needed for ovf in the last stage).
- The last stage register is the output register. sum, cout, ovf and zero all come directly from flops.
- Latency: a beat accepted at edge t has out_valid=1 after edge t+NSEG-1 when unstalled. With NSEG=1 the result is visible the cycle after acceptance.
- Throughput: one beat per cycle when out_ready=1.
- Backpressure: ready_k = !v_k || ready_{k+1}, with ready_NSEG = out_ready. in_ready = ready_0.
  - Bubbles collapse: an empty stage may fill while downstream stalls.
- While out_valid && !out_ready, sum, cout, ovf and zero hold stable.
- Capacity is NSEG beats. When all stages are valid and out_ready=0, in_ready=0.
- Simultaneous accept and consume on a full pipeline: every stage advances, and in_ready stays 1 that cycle.
- Beats leave in acceptance order. No beat is dropped or duplicated.
- Arithmetic is modulo 2^WIDTH. Flags are computed on the full WIDTH result.
- Operand values on a, b, cin and sub are don't-care when in_valid=0.

Test Plan:
1. WIDTH=16, SEG_W=4, add a=0x0001 b=0x0002 cin=0 → sum=0x0003, cout=0, ovf=0, zero=0; out_valid rises exactly 3 edges after acceptance.
2. Add a=0xFFFF b=0x0001 cin=0 → sum=0x0000, cout=1, zero=1, ovf=0 (carry crosses all 4 stage registers). Add a=0x7FFF b=0x0001 → sum=0x8000, ovf=1, cout=0.
3. Sub a=0x0005 b=0x0007 cin=1 → sum=0xFFFE, cout=0, ovf=0 (cin ignored). Sub a=0x8000 b=0x0001 → sum=0x7FFF, cout=1, ovf=1.
4. Stream 8 random beats back-to-back with out_ready=0 for 6 cycles from the first acceptance → in_ready drops once 4 beats are held; outputs stay stable while stalled; all 8 results match the golden model in order after out_ready=1.
5. Three beats in flight, pulse rst_n low for 1 cycle mid-cycle (asynchronously) → out_valid and all outputs are 0 immediately. After release, a=0x1234 b=0x4321 add → sum=0x5555 with normal latency and no stale beat.
6. Re-run scenarios 1–3 with WIDTH=8, SEG_W=8 (NSEG=1) → latency of 1 edge, same arithmetic results truncated to 8 bits (e.g. 0xFF+0x01 → 0x00, cout=1, zero=1).

Source files
------------

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined segmented carry-look-ahead add/sub with valid/ready backpressure
// One SEG_W-bit CLA per stage; carries, partial sums and unconsumed operand bits travel in stage flops.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int SEG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int NSEG = WIDTH / SEG_W;

  logic [WIDTH-1:0] b_eff;
  logic             c_first;
  logic             ovf_q, zero_q;

  assign b_eff   = sub ? ~b : b;
  assign c_first = sub | cin;

  // Every carry is a flat sum-of-products of g/p and the segment carry-in.
  function automatic logic [SEG_W:0] cla_carry(input logic [SEG_W-1:0] x,
                                                input logic [SEG_W-1:0] y,
                                                input logic             c0);
    logic [SEG_W-1:0] g, p;
    logic [SEG_W:0]   c;
    logic             term;
    g    = x & y;
    p    = x ^ y;
    c    = '0;
    c[0] = c0;
    for (int i = 1; i <= SEG_W; i++) begin
      c[i] = c0;
      for (int j = 0; j < i; j++) c[i] = c[i] & p[j];
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    return c;
  endfunction

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    localparam int UPW = WIDTH - (k + 1) * SEG_W;

    logic                   v_q, c_q, rdy, src_v, src_c;
    logic [SEG_W-1:0]       seg_a, seg_b, seg_s;
    logic [SEG_W:0]         seg_c;
    logic [(k+1)*SEG_W-1:0] acc_d, acc_q;

    if (k == 0) begin : g_src
      assign src_v = in_valid;
      assign src_c = c_first;
      assign seg_a = a[SEG_W-1:0];
      assign seg_b = b_eff[SEG_W-1:0];
      assign acc_d = seg_s;
    end else begin : g_src
      assign src_v = g_stage[k-1].v_q;
      assign src_c = g_stage[k-1].c_q;
      assign seg_a = g_stage[k-1].g_up.upa_q[SEG_W-1:0];
      assign seg_b = g_stage[k-1].g_up.upb_q[SEG_W-1:0];
      assign acc_d = {seg_s, g_stage[k-1].acc_q};
    end

    if (k == NSEG - 1) begin : g_rdy
      assign rdy = !v_q || out_ready;
    end else begin : g_rdy
      assign rdy = !v_q || g_stage[k+1].rdy;
    end

    assign seg_c = cla_carry(seg_a, seg_b, src_c);
    assign seg_s = seg_a ^ seg_b ^ seg_c[SEG_W-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        v_q   <= 1'b0;
        c_q   <= 1'b0;
        acc_q <= '0;
      end else if (rdy) begin
        v_q <= src_v;
        if (src_v) begin
          c_q   <= seg_c[SEG_W];
          acc_q <= acc_d;
        end
      end
    end

    if (UPW > 0) begin : g_up
      logic [UPW-1:0] upa_d, upb_d, upa_q, upb_q;
      if (k == 0) begin : g_d
        assign upa_d = a[WIDTH-1:SEG_W];
        assign upb_d = b_eff[WIDTH-1:SEG_W];
      end else begin : g_d
        assign upa_d = g_stage[k-1].g_up.upa_q[WIDTH-k*SEG_W-1:SEG_W];
        assign upb_d = g_stage[k-1].g_up.upb_q[WIDTH-k*SEG_W-1:SEG_W];
      end
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          upa_q <= '0;
          upb_q <= '0;
        end else if (rdy && src_v) begin
          upa_q <= upa_d;
          upb_q <= upb_d;
        end
      end
    end

    // Flags are resolved when the MSB segment is captured so they leave straight from flops.
    if (k == NSEG - 1) begin : g_flags
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (rdy && src_v) begin
          ovf_q  <= seg_c[SEG_W] ^ seg_c[SEG_W-1];
          zero_q <= (acc_d == '0);
        end
      end
    end
  end

  assign in_ready  = g_stage[0].rdy;
  assign out_valid = g_stage[NSEG-1].v_q;
  assign sum       = g_stage[NSEG-1].acc_q;
  assign cout      = g_stage[NSEG-1].c_q;
  assign ovf       = ovf_q;
  assign zero      = zero_q;

endmodule
